fpga_receiver: RTL

FPGA_RECEIVER -- requirements
Module: fpga_receiver

---
 rtl/fpga_receiver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fpga_receiver.sv
`default_nettype none
// ============================================================================
// Module   : fpga_receiver
// Purpose  : Serial byte receiver with request/acknowledge/finish handshake.
//            Optional WAIT_FIN timeout is enabled by defining FPGA_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_receiver #(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sendToOther,
   input  logic       dataIn,
   input  logic       finish,
   output logic       acknowledge,
   output logic       sent,
   output logic [7:0] dataOut,
   output logic       dataValid,
   output logic       rxError
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RECV     = 2'd1,
      S_WAIT_FIN = 2'd2,
      S_SENT     = 2'd3
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        ack_q;
   logic        sent_q;
   logic        valid_q;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("fpga_receiver: TIMEOUT_CYCLES must be nonzero");
   end

`ifdef FPGA_RX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q;
   logic            err_q;
   logic            to_hit;

   // True on the WAIT_FIN cycle whose increment would reach the limit.
   assign to_hit  = ((to_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES));
   assign rxError = err_q;
`else
   assign rxError = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         ack_q   <= 1'b0;
         sent_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef FPGA_RX_TIMEOUT_EN
         to_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
`ifdef FPGA_RX_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (sendToOther) begin
                  state_q <= S_RECV;
                  cnt_q   <= 4'd0;
                  ack_q   <= 1'b1;
               end
            end
            S_RECV: begin
               if (!sendToOther) begin
                  state_q <= S_IDLE;
                  ack_q   <= 1'b0;
               end else begin
                  shift_q <= {shift_q[6:0], dataIn};
                  cnt_q   <= cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     state_q <= S_WAIT_FIN;
`ifdef FPGA_RX_TIMEOUT_EN
                     to_q    <= '0;
`endif
                  end
               end
            end
            S_WAIT_FIN: begin
               // A withdrawn request aborts even if finish arrives alongside it.
               if (!sendToOther) begin
                  state_q <= S_IDLE;
                  ack_q   <= 1'b0;
               end else if (finish) begin
                  state_q <= S_SENT;
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                  ack_q   <= 1'b0;
                  sent_q  <= 1'b1;
               end
`ifdef FPGA_RX_TIMEOUT_EN
               else if (to_hit) begin
                  state_q <= S_IDLE;
                  ack_q   <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  to_q    <= to_q + TO_W'(1);
               end
`endif
            end
            S_SENT: begin
               if (!sendToOther && !finish) begin
                  state_q <= S_IDLE;
                  sent_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign acknowledge = ack_q;
   assign sent        = sent_q;
   assign dataOut     = data_q;
   assign dataValid   = valid_q;

endmodule
`default_nettype wire
